led_pattern_gen: RTL
====================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000: input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1000: timebase tick rate in Hz; CLK_HZ/TICK_HZ integer and >= 2.
REQ-003 SHALL have parameter N_CH, default 4: number of LED channels, 1..16.
REQ-004 SHALL have parameter DEFAULT_HALF, default 500: per-channel half-period reset value, in ticks.
REQ-005 SHALL have parameter PWM_BITS, default 4: brightness resolution in bits.
REQ-006 SHALL have ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  global run enable.
- mode  in  2*N_CH  per-channel mode; bits [2c+1:2c] belong to channel c.
- wr_en  in  1  half-period write strobe.
- wr_ch  in  4  target channel of the write.
- wr_half  in  16  half-period value to write, in ticks.
- brightness  in  PWM_BITS  dimming duty.
- tick  out  1  one-cycle timebase pulse.
- led  out  N_CH  LED drive, bit c = channel c.

Function
REQ-007 SHALL run a prescaler counting 0..DIV-1, with DIV = CLK_HZ/TICK_HZ, while en=1; tick=1 for exactly the one cycle after the count reaches DIV-1, and the prescaler wraps to 0.
REQ-008 SHALL, while en=0, hold the prescaler, all channel counters and all channel phases, keep tick=0, and drive led=0.
REQ-009 SHALL keep a 16-bit half-period register per channel, reset to DEFAULT_HALF.
REQ-010 SHALL act on wr_en=1 with wr_ch < N_CH as follows:
- load wr_half into that channel's half-period register, with a value of 0 stored as 1;
- clear that channel's tick counter and phase in the same cycle;
- a write SHALL take priority over a tick in the same cycle.
REQ-011 SHALL ignore writes with wr_ch >= N_CH, with no state change.
REQ-012 SHALL implement these channel modes:
- 00 OFF: led=0.
- 01 ON: led=1.
- 10 BLINK: led=phase.
- 11 ONESHOT: led=1 for half-period ticks, then 0.
REQ-013 SHALL in BLINK, on each tick, increment the channel counter; when counter = half-1, clear the counter and toggle phase; period = 2*half ticks, 50% duty.
REQ-014 SHALL in ONESHOT, on entry (previous registered mode != 11), clear the counter and set phase=1; on reaching half-1, clear phase and hold it at 0; re-arming requires leaving mode 11 and re-entering it.
REQ-015 SHALL in OFF and ON, hold the channel counter and phase at 0.
REQ-016 SHALL, on any mode change, clear the channel counter and phase at the next clock edge.
REQ-017 SHALL register led, updating one clk after the state that determines it.
REQ-018 SHALL keep channels fully independent; simultaneous writes to one channel and ticks on the others SHALL not interact.

Reset
REQ-019 SHALL, while rst_n=0, asynchronously set led=0, tick=0, the prescaler to 0, all counters and phases to 0, all half-periods to DEFAULT_HALF, all stored previous modes to 00, and the PWM counter to 0.
REQ-020 SHALL, on rst_n assertion mid-period, abandon all timing; the first tick after release SHALL come DIV cycles after the first rising edge with rst_n=1 and en=1.

Configuration
REQ-021 SHALL, with LED_PWM_DIM_EN defined, run a free-running PWM_BITS counter, gate each led bit with (pwm_cnt < brightness) after the mode logic, and force full-on when brightness is all-ones.
REQ-022 SHALL, without LED_PWM_DIM_EN, omit the PWM counter, ignore brightness, and drive led directly from the mode logic.

Verification (CLK_HZ=100, TICK_HZ=10, DIV=10, N_CH=4)
REQ-023 SHALL cover: release rst_n with en=1 -> first tick 10 cycles after release, then every 10 cycles; assert rst_n=0 mid-blink -> led=0 and tick=0 immediately, with no clock edge required.
REQ-024 SHALL cover: ch0 BLINK with wr_half=3 -> led[0] toggles every 30 cycles; en=0 for 7 cycles mid-period -> toggle delayed by exactly 7 cycles.
REQ-025 SHALL cover: write wr_ch=2, wr_half=0, in the same cycle as a tick -> half stored as 1, phase cleared, next toggle at the following tick (10 cycles later).
REQ-026 SHALL cover: ch1 ONESHOT with half=2 -> led[1] high for 20 cycles, then low indefinitely; OFF then ONESHOT -> fires again; a write to wr_ch=5 -> no channel changes.
REQ-027 SHALL cover: ch3 ON with LED_PWM_DIM_EN, PWM_BITS=4, brightness=4 -> led[3] high 4 of every 16 cycles; brightness=15 -> constantly high; without the macro -> constantly high for any brightness.

Source files
------------

// File: rtl/led_pattern_gen.sv
// Purpose : multi-channel LED pattern generator (off / on / blink / one-shot) on a shared tick timebase.
// Latency : tick one cycle after the prescaler reaches DIV-1; led registered one cycle after channel state.
// Backpres: none; writes and mode changes are accepted every cycle.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   en                   global run enable; 0 freezes all timing and blanks led
//   mode[2c+1:2c]        channel c mode: 00 off, 01 on, 10 blink, 11 one-shot
//   wr_en/wr_ch/wr_half  half-period write (ticks) to one channel; 0 is stored as 1
//   brightness           dimming duty, used only when LED_PWM_DIM_EN is defined
//   tick                 one-cycle timebase pulse
//   led[c]               LED drive for channel c
// Build option: define LED_PWM_DIM_EN to gate led with a free-running PWM_BITS dimmer.
module led_pattern_gen #(
  parameter int CLK_HZ       = 100000000,
  parameter int TICK_HZ      = 1000,
  parameter int N_CH         = 4,
  parameter int DEFAULT_HALF = 500,
  parameter int PWM_BITS     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [2*N_CH-1:0]     mode,
  input  logic                  wr_en,
  input  logic [3:0]            wr_ch,
  input  logic [15:0]           wr_half,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic                  tick,
  output logic [N_CH-1:0]       led
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  // ---------------- prescaler ----------------
  logic [PW-1:0] pre_cnt;
  logic          tick_q;

  // tick_q is held (not cleared) while en=0 so a pause that lands on a tick
  // cycle delays that tick instead of dropping it; the output is masked by en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      tick_q  <= 1'b0;
    end else if (en) begin
      if (pre_cnt == PW'(DIV - 1)) begin
        pre_cnt <= '0;
        tick_q  <= 1'b1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
        tick_q  <= 1'b0;
      end
    end
  end

  assign tick = tick_q & en;

  // ---------------- channel state ----------------
  logic [N_CH-1:0][1:0]  cur_mode;
  logic [N_CH-1:0][15:0] half_q, half_d;
  logic [N_CH-1:0][15:0] cnt_q, cnt_d;
  logic [N_CH-1:0]       phase_q, phase_d;
  logic [N_CH-1:0][1:0]  prev_mode_q, prev_mode_d;
  logic [N_CH-1:0]       wr_hit;
  logic [N_CH-1:0]       led_d;
  logic                  pwm_gate;
  logic [N_CH-1:0]       led_q;

  assign cur_mode = mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_q      <= {N_CH{16'(DEFAULT_HALF)}};
      cnt_q       <= '0;
      phase_q     <= '0;
      prev_mode_q <= '0;
      led_q       <= '0;
    end else begin
      half_q      <= half_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      prev_mode_q <= prev_mode_d;
      led_q       <= led_d & {N_CH{pwm_gate}};
    end
  end

  always_comb begin
    half_d      = half_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    prev_mode_d = prev_mode_q;
    wr_hit      = '0;
    led_d       = '0;
    for (int c = 0; c < N_CH; c++) begin
      // Channels >= N_CH never match, so out-of-range writes are dropped.
      wr_hit[c] = wr_en && (wr_ch == 4'(c));
      if (wr_hit[c]) begin
        half_d[c]  = (wr_half == 16'd0) ? 16'd1 : wr_half;
        cnt_d[c]   = '0;
        phase_d[c] = 1'b0;
      end
      if (en) begin
        // prev_mode only advances while running, so a mode change made during
        // a pause is still seen as an entry when en returns.
        prev_mode_d[c] = cur_mode[c];
        if (!wr_hit[c]) begin
          if (cur_mode[c] != prev_mode_q[c]) begin
            cnt_d[c]   = '0;
            phase_d[c] = (cur_mode[c] == MODE_ONESHOT);
          end else begin
            case (cur_mode[c])
              MODE_BLINK: begin
                if (tick_q) begin
                  if (cnt_q[c] == half_q[c] - 16'd1) begin
                    cnt_d[c]   = '0;
                    phase_d[c] = ~phase_q[c];
                  end else begin
                    cnt_d[c] = cnt_q[c] + 16'd1;
                  end
                end
              end
              MODE_ONESHOT: begin
                // phase=0 means the shot is spent; stay idle until re-entry.
                if (tick_q && phase_q[c]) begin
                  if (cnt_q[c] == half_q[c] - 16'd1) begin
                    cnt_d[c]   = '0;
                    phase_d[c] = 1'b0;
                  end else begin
                    cnt_d[c] = cnt_q[c] + 16'd1;
                  end
                end
              end
              default: begin
                cnt_d[c]   = '0;
                phase_d[c] = 1'b0;
              end
            endcase
          end
        end
        case (cur_mode[c])
          MODE_ON:      led_d[c] = 1'b1;
          MODE_BLINK:   led_d[c] = phase_q[c];
          MODE_ONESHOT: led_d[c] = phase_q[c];
          default:      led_d[c] = 1'b0;
        endcase
      end
    end
  end

  // ---------------- optional dimmer ----------------
`ifdef LED_PWM_DIM_EN
  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // All-ones brightness is full-on; the compare alone would miss one slot.
  assign pwm_gate = (pwm_cnt < brightness) || (&brightness);
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign pwm_gate = 1'b1;
`endif

  assign led = led_q;

endmodule
